fixed_div: RTL

Sequential signed fixed-point divider for the Q8.8 datapath, the inverse of the combinational `fixed_mul`. It computes `result = a / b` in the same Q format, one quotient bit per clock, using restoring division on operand magnitudes. Results saturate and are truncated toward zero. It sits alongside `fixed_mul` in the arithmetic units and uses a start/done handshake so callers can issue back-to-back divisions.

---
 rtl/fixed_div.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fixed_div.sv
// rtl/fixed_div.sv - sequential signed fixed-point divider (restoring, one quotient bit per clock)
module fixed_div #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW);

  localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QW-1:0]    POS_LIM = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]    NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_nxt;

  logic             sign;
  logic             a_neg;
  logic             b_zero;
  logic [WIDTH:0]   bmag;
  logic [WIDTH:0]   rem;
  logic [QW-1:0]    dvd;
  logic [QW-1:0]    quo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_ext, b_ext, amag_in, bmag_in;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] res_nxt;
  logic             ov_nxt;

  // Sign-extend before negating so -2^(WIDTH-1) has an exact magnitude.
  assign a_ext   = {a[WIDTH-1], a};
  assign b_ext   = {b[WIDTH-1], b};
  assign amag_in = a[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
  assign bmag_in = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;

  assign rem_sh = {rem[WIDTH-1:0], dvd[QW-1]};
  assign rem_ge = (rem_sh >= bmag);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (b == '0) ? FINISH : CALC;
      CALC:    if (cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign is applied after the magnitude quotient, giving truncation toward zero.
  always_comb begin
    res_nxt = quo[WIDTH-1:0];
    ov_nxt  = 1'b0;
    if (b_zero) begin
      res_nxt = a_neg ? RES_MIN : RES_MAX;
    end else if (!sign && (quo > POS_LIM)) begin
      res_nxt = RES_MAX;
      ov_nxt  = 1'b1;
    end else if (sign && (quo > NEG_LIM)) begin
      res_nxt = RES_MIN;
      ov_nxt  = 1'b1;
    end else if (sign) begin
      res_nxt = WIDTH'(0) - quo[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      sign        <= 1'b0;
      a_neg       <= 1'b0;
      b_zero      <= 1'b0;
      bmag        <= '0;
      rem         <= '0;
      dvd         <= '0;
      quo         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign   <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg  <= a[WIDTH-1];
            b_zero <= (b == '0);
            bmag   <= bmag_in;
            dvd    <= {amag_in[WIDTH-1:0], {FRAC{1'b0}}};
            rem    <= '0;
            quo    <= '0;
            cnt    <= CW'(QW - 1);
          end
        end
        CALC: begin
          rem <= rem_ge ? (rem_sh - bmag) : rem_sh;
          quo <= {quo[QW-2:0], rem_ge};
          dvd <= {dvd[QW-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FINISH: begin
          result      <= res_nxt;
          overflow    <= ov_nxt;
          div_by_zero <= b_zero;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
